// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner: sync, debounce, press/release pulses.
// Optional typematic auto-repeat of press pulses under DEBOUNCE_REPEAT_EN.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   button      raw bouncing pins, active-high, asynchronous
//   btn         debounced level per channel
//   btn_press   1-cycle pulse per accepted 0->1 (and per repeat if enabled)
//   btn_release 1-cycle pulse per accepted 1->0
//   any_press   OR of btn_press, same cycle
//
// Macro: DEBOUNCE_REPEAT_EN enables auto-repeat (REPEAT_DELAY/REPEAT_PERIOD).
module btn_debounce_multi #(
  parameter int N_BTN         = 5,
  parameter int STABLE_CYCLES = 100000,
  parameter int CNT_W         = 17,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] button,
  output logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);

  // Illegal configurations elaborate an empty marker block; the
  // parameters are constrained by their documented ranges.
  if (STABLE_CYCLES < 2 || SYNC_STAGES < 2) begin : g_bad_cfg
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [N_BTN-1:0] sync_q [SYNC_STAGES];
  logic [N_BTN-1:0] samp;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [N_BTN-1:0] accept;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] press_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= button;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign samp = sync_q[SYNC_STAGES-1];

  always_comb begin
    accept = '0;
    for (int i = 0; i < N_BTN; i++) begin
      accept[i] = (samp[i] != btn[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign rise = accept & samp;
  assign fall = accept & ~samp;

  // The count only advances while samp disagrees with btn, so any
  // bounce back to the current level restarts it from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (samp[i] == btn[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          cnt[i] <= '0;
          btn[i] <= samp[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W = $clog2(RMAX + 1);
  localparam logic [RPT_W-1:0] R_DLY = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] R_PER = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rcnt [N_BTN];
  logic [N_BTN-1:0] rphase;
  logic [N_BTN-1:0] rep_hit;

  // rphase selects the initial delay (0) or the steady period (1).
  always_comb begin
    rep_hit = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rep_hit[i] = btn[i] && !accept[i] &&
        (rcnt[i] == (rphase[i] ? R_PER : R_DLY));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rphase <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        rcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (accept[i] || !btn[i]) begin
          rcnt[i] <= '0;
          rphase[i] <= 1'b0;
        end else if (rep_hit[i]) begin
          rcnt[i] <= '0;
          rphase[i] <= 1'b1;
        end else begin
          rcnt[i] <= rcnt[i] + 1'b1;
        end
      end
    end
  end

  assign press_d = rise | rep_hit;
`else
  assign press_d = rise;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_press <= '0;
      btn_release <= '0;
      any_press <= 1'b0;
    end else begin
      btn_press <= press_d;
      btn_release <= fall;
      any_press <= |press_d;
    end
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Scoreboard bench for btn_debounce_multi: history-based reference model
// predicts every output cycle; a negedge monitor pops and compares.
module tb_btn_debounce_multi;

  localparam int N  = 5;
  localparam int ST = 4;
  localparam int SY = 2;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef DEBOUNCE_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0] b;
    logic [N-1:0] p;
    logic [N-1:0] r;
    logic         a;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] button = '0;
  logic [N-1:0] btn;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic         any_press;

  int checks = 0;
  int errors = 0;

  btn_debounce_multi #(
    .N_BTN(N),
    .STABLE_CYCLES(ST),
    .CNT_W(3),
    .SYNC_STAGES(SY),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .button(button),
    .btn(btn),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .any_press(any_press)
  );

  always #5 clk = ~clk;

  // Reference model: pin history indexed by edge number since reset.
  exp_t         q[$];
  logic [N-1:0] hist[$];
  logic [N-1:0] mb;
  int           last_acc[N];
  int           e;

  function automatic logic samp_at(int x, int i);
    if (x - SY >= 1) return hist[x-SY-1][i];
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      hist.delete();
      mb = '0;
      e = 0;
      for (int i = 0; i < N; i++) last_acc[i] = 0;
    end else begin
      exp_t x;
      logic acc;
      int d;
      x = '0;
      e++;
      hist.push_back(button);
      for (int i = 0; i < N; i++) begin
        acc = 1'b0;
        // Accept when the last ST synchronised samples all differ from
        // the level and none of them precede the previous acceptance.
        if (e - last_acc[i] >= ST) begin
          acc = 1'b1;
          for (int k = 0; k < ST; k++)
            if (samp_at(e - k, i) == mb[i]) acc = 1'b0;
        end
        if (acc) begin
          x.p[i] = ~mb[i];
          x.r[i] = mb[i];
          x.b[i] = ~mb[i];
          last_acc[i] = e;
        end else begin
          x.b[i] = mb[i];
          if (REP && mb[i]) begin
            d = e - last_acc[i];
            if (d == RD || (d > RD && (d - RD) % RP == 0)) x.p[i] = 1'b1;
          end
        end
      end
      x.a = |x.p;
      mb = x.b;
      q.push_back(x);
    end
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      if (btn !== x.b || btn_press !== x.p ||
          btn_release !== x.r || any_press !== x.a) begin
        errors++;
        $display("FAIL cycle t=%0t got btn=%b press=%b rel=%b any=%b want btn=%b press=%b rel=%b any=%b",
          $time, btn, btn_press, btn_release, any_press,
          x.b, x.p, x.r, x.a);
      end
      checks++;
      if ((btn_press & btn_release) !== '0) begin
        errors++;
        $display("FAIL press_release_overlap got %b want 0",
          btn_press & btn_release);
      end
    end
  end

  task automatic hold(input logic [N-1:0] v, input int n);
    repeat (n) begin
      @(negedge clk);
      button = v;
    end
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({btn, btn_press, btn_release, any_press} !== '0) begin
      errors++;
      $display("FAIL async_reset_%s got %b want 0", tag,
        {btn, btn_press, btn_release, any_press});
    end
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] v;
    button = '0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({btn, btn_press, btn_release, any_press} !== '0) begin
      errors++;
      $display("FAIL reset_state got %b want 0",
        {btn, btn_press, btn_release, any_press});
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    hold('0, 3);
    // clean step on channel 0
    hold(5'b00001, 12);
    // bounce on channel 1 then hold
    hold(5'b00011, 2);
    hold(5'b00001, 2);
    hold(5'b00011, 2);
    hold(5'b00001, 2);
    hold(5'b00011, 12);
    // channel 2 press then release
    hold(5'b00111, 10);
    hold(5'b00011, 12);
    // release all, then simultaneous step on 0 and 4
    hold(5'b00000, 12);
    hold(5'b10001, 12);
    hold(5'b00000, 12);
    // reset mid-count
    hold(5'b00100, 3);
    async_reset("midcount");
    hold(5'b00000, 10);
    // reset while held, button stays held
    hold(5'b01000, 10);
    async_reset("held");
    hold(5'b01000, 12);
    hold(5'b00000, 10);
    // long hold on channel 3 for auto-repeat, then release
    hold(5'b01000, 30);
    hold(5'b00000, 12);
    // randomised bouncing on all channels
    v = '0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 6) == 0) v[i] = ~v[i];
      hold(v, ($urandom_range(0, 3) == 0) ? 6 : 1);
    end
    hold('0, 30);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
